lpif_link_bringup_ctrl: RTL and testbench

Sequences link bring-up for the LPIF x16 asym2 quarter-rate master datapath. Waits for all AIB channels to be ready, then drives tx_online, and after a settle interval drives rx_online. It then waits for per-channel receive alignment, and retrains with a bounded retry count on timeout, error or PHY drop. It sits above the datapath top and drives its tx_online/rx_online inputs; its status word feeds the debug register bank.

---
 rtl/lpif_link_bringup_ctrl_pkg.sv | 25 ++
 rtl/lpif_link_bringup_ctrl_if.sv | 30 +++
 rtl/lpif_link_bringup_ctrl_timer.sv | 35 +++
 rtl/lpif_link_bringup_ctrl.sv | 177 +++++++++++++++++
 tb/tb_lpif_link_bringup_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpif_link_bringup_ctrl_pkg.sv
// Shared types and constants for the LPIF link bring-up controller.
// State encodings are visible in the debug status word.
package lpif_ctrl_pkg;

  localparam int LPIF_CTRL_STATE_W = 3;

  typedef enum logic [LPIF_CTRL_STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_WAIT_PHY  = 3'd1,
    S_TX_SETTLE = 3'd2,
    S_RX_ALIGN  = 3'd3,
    S_LINK_UP   = 3'd4,
    S_HOLDOFF   = 3'd5,
    S_FAIL      = 3'd6,
    S_RSVD      = 3'd7
  } lpif_ctrl_state_e;

  localparam int DBG_TX_BIT    = 0;
  localparam int DBG_RX_BIT    = 1;
  localparam int DBG_UP_BIT    = 2;
  localparam int DBG_FAIL_BIT  = 3;
  localparam int DBG_STATE_LSB = 8;
  localparam int DBG_RETRY_LSB = 12;

endpackage

// File: rtl/lpif_link_bringup_ctrl_if.sv
// Control/status bundle between software/PHY side and the bring-up FSM.
// The controller uses the slave view; the stimulus side uses master.
interface lpif_link_bringup_ctrl_if #(
  parameter int NUM_CH  = 4,
  parameter int RETRY_W = 2
);
  logic              link_en;
  logic [NUM_CH-1:0] phy_ready;
  logic [NUM_CH-1:0] rx_align_done;
  logic              rx_err;
  logic              tx_online;
  logic              rx_online;
  logic              link_up;
  logic              link_fail;
  logic [2:0]        ctrl_state;
  logic [RETRY_W-1:0] retry_cnt;
  logic [31:0]       ctrl_debug_status;

  modport master (
    output link_en, phy_ready, rx_align_done, rx_err,
    input  tx_online, rx_online, link_up, link_fail,
    input  ctrl_state, retry_cnt, ctrl_debug_status
  );

  modport slave (
    input  link_en, phy_ready, rx_align_done, rx_err,
    output tx_online, rx_online, link_up, link_fail,
    output ctrl_state, retry_cnt, ctrl_debug_status
  );
endinterface

// File: rtl/lpif_link_bringup_ctrl_timer.sv
// Down-counter shared by the settle, align-timeout and holdoff phases.
// Load has priority; the FSM never requests load and decrement together.
module lpif_ctrl_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk_wr,
  input  logic             rst_wr,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - TMR_W'(1);
    end
  end

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/lpif_link_bringup_ctrl.sv
// Link bring-up sequencer: PHY ready -> tx_online -> settle -> rx_online
// -> alignment, with bounded retries on timeout, rx_err or PHY drop.
module lpif_link_bringup_ctrl
  import lpif_ctrl_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int TMR_W         = 16,
  parameter int SETTLE_CYC    = 64,
  parameter int ALIGN_TIMEOUT = 4096,
  parameter int HOLDOFF_CYC   = 32,
  parameter int MAX_RETRY     = 3
) (
  input  logic clk_wr,
  input  logic rst_wr,
  lpif_link_bringup_ctrl_if.slave bus
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] ALIGN_LD  = TMR_W'(ALIGN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLDOFF_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX_V = RETRY_W'(MAX_RETRY);

  lpif_ctrl_state_e   state_q;
  logic [RETRY_W-1:0] retry_q;
  logic               tx_q, rx_q, up_q, fail_q;

  logic [NUM_CH-1:0] phy_w, align_w;
  logic              phy_all, align_all;
  logic              retry_max, fail_evt;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]  tmr_val;
  logic [31:0]       dbg;

  assign phy_w     = bus.phy_ready;
  assign align_w   = bus.rx_align_done;
  assign phy_all   = &phy_w;
  assign align_all = &align_w;
  assign retry_max = (retry_q == RETRY_MAX_V);

  // PHY loss outranks alignment; alignment outranks the timeout
  always_comb begin
    fail_evt = 1'b0;
    if (bus.link_en) begin
      unique case (state_q)
        S_TX_SETTLE: fail_evt = !phy_all;
        S_RX_ALIGN:  fail_evt = !phy_all || (!align_all && tmr_zero);
        S_LINK_UP:   fail_evt = bus.rx_err || !phy_all;
        default:     fail_evt = 1'b0;
      endcase
    end
  end

  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    if (!bus.link_en) begin
      tmr_load = 1'b0;
    end else if (fail_evt) begin
      tmr_load = !retry_max;
      tmr_val  = HOLD_LD;
    end else begin
      unique case (state_q)
        S_WAIT_PHY: begin
          tmr_load = phy_all;
          tmr_val  = SETTLE_LD;
        end
        S_TX_SETTLE: begin
          tmr_load = tmr_zero;
          tmr_val  = ALIGN_LD;
          tmr_dec  = !tmr_zero;
        end
        S_RX_ALIGN: tmr_dec = !align_all;
        S_HOLDOFF:  tmr_dec = !tmr_zero;
        default:    tmr_dec = 1'b0;
      endcase
    end
  end

  lpif_ctrl_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk_wr   (clk_wr),
    .rst_wr   (rst_wr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      state_q <= S_IDLE;
      retry_q <= '0;
      tx_q    <= 1'b0;
      rx_q    <= 1'b0;
      up_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else if (!bus.link_en) begin
      state_q <= S_IDLE;
      retry_q <= '0;
      tx_q    <= 1'b0;
      rx_q    <= 1'b0;
      up_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else if (fail_evt) begin
      tx_q <= 1'b0;
      rx_q <= 1'b0;
      up_q <= 1'b0;
      if (retry_max) begin
        state_q <= S_FAIL;
        fail_q  <= 1'b1;
      end else begin
        state_q <= S_HOLDOFF;
        retry_q <= retry_q + RETRY_W'(1);
      end
    end else begin
      unique case (state_q)
        S_IDLE: state_q <= S_WAIT_PHY;
        S_WAIT_PHY: begin
          if (phy_all) begin
            state_q <= S_TX_SETTLE;
            tx_q    <= 1'b1;
          end
        end
        S_TX_SETTLE: begin
          if (tmr_zero) begin
            state_q <= S_RX_ALIGN;
            rx_q    <= 1'b1;
          end
        end
        S_RX_ALIGN: begin
          if (align_all) begin
            state_q <= S_LINK_UP;
            up_q    <= 1'b1;
            retry_q <= '0;
          end
        end
        S_LINK_UP: state_q <= S_LINK_UP;
        S_HOLDOFF: begin
          if (tmr_zero) begin
            state_q <= S_WAIT_PHY;
          end
        end
        S_FAIL: fail_q <= 1'b1;
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b0;
          rx_q    <= 1'b0;
          up_q    <= 1'b0;
          fail_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    dbg = '0;
    dbg[DBG_TX_BIT]   = tx_q;
    dbg[DBG_RX_BIT]   = rx_q;
    dbg[DBG_UP_BIT]   = up_q;
    dbg[DBG_FAIL_BIT] = fail_q;
    dbg[DBG_STATE_LSB +: LPIF_CTRL_STATE_W] = state_q;
    dbg[DBG_RETRY_LSB +: RETRY_W] = retry_q;
  end

  assign bus.tx_online         = tx_q;
  assign bus.rx_online         = rx_q;
  assign bus.link_up           = up_q;
  assign bus.link_fail         = fail_q;
  assign bus.ctrl_state        = state_q;
  assign bus.retry_cnt         = retry_q;
  assign bus.ctrl_debug_status = dbg;

endmodule

// File: tb/tb_lpif_link_bringup_ctrl.sv
// Directed bench for the LPIF link bring-up controller.
// Cycle n means n rising edges after reset release.
module tb_lpif_link_bringup_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  lpif_link_bringup_ctrl_if #(.NUM_CH(4), .RETRY_W(2)) bus ();

  lpif_link_bringup_ctrl #(
    .NUM_CH(4), .TMR_W(16), .SETTLE_CYC(64),
    .ALIGN_TIMEOUT(4096), .HOLDOFF_CYC(32), .MAX_RETRY(3)
  ) dut (
    .clk_wr (clk),
    .rst_wr (rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [3:0] align);
    rst = 1'b1;
    bus.link_en = 1'b1;
    bus.phy_ready = 4'hF;
    bus.rx_align_done = align;
    bus.rx_err = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [9:0] obs;
    do_reset(4'h0);
    rst = 1'b1;
    tick(1);
    obs = {bus.ctrl_state, bus.retry_cnt, bus.link_fail,
           bus.link_up, bus.rx_online, bus.tx_online, 1'b0};
    checks++;
    if (obs !== 10'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 000", obs);
    end
    checks++;
    if (bus.ctrl_debug_status !== 32'h0) begin
      errors++;
      $display("FAIL reset_debug got %h exp 0", bus.ctrl_debug_status);
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (bus.ctrl_state !== 3'd1 || bus.tx_online !== 1'b0) begin
      errors++;
      $display("FAIL c1_wait_phy got st=%0d tx=%b exp st=1 tx=0",
               bus.ctrl_state, bus.tx_online);
    end
    tick(1);
    checks++;
    if (bus.ctrl_state !== 3'd2 || bus.tx_online !== 1'b1) begin
      errors++;
      $display("FAIL c2_tx_online got st=%0d tx=%b exp st=2 tx=1",
               bus.ctrl_state, bus.tx_online);
    end
    tick(63);
    checks++;
    if (bus.rx_online !== 1'b0) begin
      errors++;
      $display("FAIL c65_rx_low got %b exp 0", bus.rx_online);
    end
    tick(1);
    checks++;
    if (bus.rx_online !== 1'b1 || bus.ctrl_state !== 3'd3) begin
      errors++;
      $display("FAIL c66_rx_online got rx=%b st=%0d exp rx=1 st=3",
               bus.rx_online, bus.ctrl_state);
    end
    tick(34);
    bus.rx_align_done = 4'hF;
    checks++;
    if (bus.link_up !== 1'b0) begin
      errors++;
      $display("FAIL c100_link_up_early got %b exp 0", bus.link_up);
    end
    tick(1);
    checks++;
    if (bus.link_up !== 1'b1 || bus.retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL c101_link_up got up=%b retry=%0d exp up=1 retry=0",
               bus.link_up, bus.retry_cnt);
    end
    checks++;
    if (bus.ctrl_debug_status !== 32'h0000_0407) begin
      errors++;
      $display("FAIL up_debug got %h exp 00000407",
               bus.ctrl_debug_status);
    end
  endtask

  task automatic test_timeout;
    logic [2:0] exp_st;
    logic [1:0] exp_rt;
    do_reset(4'h7);
    tick(4161);
    checks++;
    if (bus.ctrl_state !== 3'd3 || bus.tx_online !== 1'b1) begin
      errors++;
      $display("FAIL to1_before got st=%0d tx=%b exp st=3 tx=1",
               bus.ctrl_state, bus.tx_online);
    end
    tick(1);
    checks++;
    if (bus.ctrl_state !== 3'd5 || bus.retry_cnt !== 2'd1 ||
        bus.tx_online !== 1'b0 || bus.rx_online !== 1'b0) begin
      errors++;
      $display("FAIL to1_holdoff got st=%0d rt=%0d tx=%b rx=%b exp 5 1 0 0",
               bus.ctrl_state, bus.retry_cnt, bus.tx_online, bus.rx_online);
    end
    tick(31);
    checks++;
    if (bus.ctrl_state !== 3'd5) begin
      errors++;
      $display("FAIL holdoff_len got st=%0d exp 5", bus.ctrl_state);
    end
    tick(1);
    checks++;
    if (bus.ctrl_state !== 3'd1) begin
      errors++;
      $display("FAIL holdoff_exit got st=%0d exp 1", bus.ctrl_state);
    end
    for (int k = 2; k <= 4; k++) begin
      tick(4160 + (k == 2 ? 0 : 32));
      checks++;
      if (bus.ctrl_state !== 3'd3) begin
        errors++;
        $display("FAIL to%0d_before got st=%0d exp 3", k, bus.ctrl_state);
      end
      tick(1);
      exp_st = (k == 4) ? 3'd6 : 3'd5;
      exp_rt = (k == 4) ? 2'd3 : 2'(k);
      checks++;
      if (bus.ctrl_state !== exp_st || bus.retry_cnt !== exp_rt) begin
        errors++;
        $display("FAIL to%0d_after got st=%0d rt=%0d exp st=%0d rt=%0d",
                 k, bus.ctrl_state, bus.retry_cnt, exp_st, exp_rt);
      end
    end
    checks++;
    if (bus.ctrl_debug_status !== 32'h0000_3608) begin
      errors++;
      $display("FAIL fail_debug got %h exp 00003608",
               bus.ctrl_debug_status);
    end
    tick(100);
    checks++;
    if (bus.ctrl_state !== 3'd6 || bus.link_fail !== 1'b1 ||
        bus.tx_online !== 1'b0) begin
      errors++;
      $display("FAIL fail_sticky got st=%0d lf=%b tx=%b exp 6 1 0",
               bus.ctrl_state, bus.link_fail, bus.tx_online);
    end
  endtask

  task automatic test_fail_recover;
    bus.link_en = 1'b0;
    tick(1);
    bus.link_en = 1'b1;
    bus.rx_align_done = 4'hF;
    checks++;
    if (bus.ctrl_state !== 3'd0 || bus.retry_cnt !== 2'd0 ||
        bus.link_fail !== 1'b0) begin
      errors++;
      $display("FAIL fail_exit got st=%0d rt=%0d lf=%b exp 0 0 0",
               bus.ctrl_state, bus.retry_cnt, bus.link_fail);
    end
    tick(66);
    checks++;
    if (bus.ctrl_state !== 3'd3) begin
      errors++;
      $display("FAIL relaunch_rx got st=%0d exp 3", bus.ctrl_state);
    end
    tick(1);
    checks++;
    if (bus.link_up !== 1'b1 || bus.ctrl_state !== 3'd4) begin
      errors++;
      $display("FAIL relaunch_up got up=%b st=%0d exp 1 4",
               bus.link_up, bus.ctrl_state);
    end
  endtask

  task automatic test_rx_err;
    bus.rx_err = 1'b1;
    tick(1);
    bus.rx_err = 1'b0;
    checks++;
    if (bus.ctrl_state !== 3'd5 || bus.retry_cnt !== 2'd1 ||
        bus.tx_online !== 1'b0 || bus.rx_online !== 1'b0 ||
        bus.link_up !== 1'b0) begin
      errors++;
      $display("FAIL rx_err_drop got st=%0d rt=%0d tx=%b rx=%b up=%b",
               bus.ctrl_state, bus.retry_cnt, bus.tx_online,
               bus.rx_online, bus.link_up);
    end
    tick(31);
    checks++;
    if (bus.ctrl_state !== 3'd5) begin
      errors++;
      $display("FAIL rx_err_hold got st=%0d exp 5", bus.ctrl_state);
    end
    tick(1);
    tick(66);
    checks++;
    if (bus.ctrl_state !== 3'd4 || bus.retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL relock got st=%0d rt=%0d exp 4 0",
               bus.ctrl_state, bus.retry_cnt);
    end
  endtask

  task automatic test_phy_drop;
    do_reset(4'h0);
    tick(55);
    bus.phy_ready = 4'hB;
    tick(1);
    checks++;
    if (bus.ctrl_state !== 3'd5 || bus.retry_cnt !== 2'd1 ||
        bus.tx_online !== 1'b0) begin
      errors++;
      $display("FAIL phy_drop got st=%0d rt=%0d tx=%b exp 5 1 0",
               bus.ctrl_state, bus.retry_cnt, bus.tx_online);
    end
    tick(100);
    checks++;
    if (bus.rx_online !== 1'b0 || bus.ctrl_state !== 3'd1) begin
      errors++;
      $display("FAIL phy_drop_rx got rx=%b st=%0d exp 0 1",
               bus.rx_online, bus.ctrl_state);
    end
    bus.phy_ready = 4'hF;
    tick(4160);
    bus.rx_align_done = 4'hF;
    checks++;
    if (bus.ctrl_state !== 3'd3) begin
      errors++;
      $display("FAIL tie_before got st=%0d exp 3", bus.ctrl_state);
    end
    tick(1);
    checks++;
    if (bus.ctrl_state !== 3'd4 || bus.retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL tie_align_wins got st=%0d rt=%0d exp 4 0",
               bus.ctrl_state, bus.retry_cnt);
    end
  endtask

  task automatic test_en_vs_align;
    do_reset(4'h0);
    tick(80);
    bus.link_en = 1'b0;
    bus.rx_align_done = 4'hF;
    tick(1);
    checks++;
    if (bus.ctrl_state !== 3'd0 || bus.link_up !== 1'b0 ||
        bus.tx_online !== 1'b0 || bus.rx_online !== 1'b0) begin
      errors++;
      $display("FAIL en_wins got st=%0d up=%b tx=%b rx=%b exp 0 0 0 0",
               bus.ctrl_state, bus.link_up, bus.tx_online, bus.rx_online);
    end
    tick(3);
    checks++;
    if (bus.link_up !== 1'b0 || bus.ctrl_state !== 3'd0) begin
      errors++;
      $display("FAIL en_hold got up=%b st=%0d exp 0 0",
               bus.link_up, bus.ctrl_state);
    end
  endtask

  task automatic test_reset_in_linkup;
    bus.link_en = 1'b1;
    tick(67);
    checks++;
    if (bus.link_up !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_up got %b exp 1", bus.link_up);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (bus.ctrl_debug_status !== 32'h0 || bus.retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL rst_in_up got dbg=%h rt=%0d exp 0 0",
               bus.ctrl_debug_status, bus.retry_cnt);
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.link_en = 1'b0;
    bus.phy_ready = 4'h0;
    bus.rx_align_done = 4'h0;
    bus.rx_err = 1'b0;
    test_reset();
    test_timeout();
    test_fail_recover();
    test_rx_err();
    test_phy_drop();
    test_en_vs_align();
    test_reset_in_linkup();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
